// File: rtl/boot_loader.sv
// Boot sequencer: holds the core in reset, streams a little-endian program image
// into instruction memory, verifies an 8-bit payload checksum, then releases the core.
module boot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_in,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    input  logic                  reload_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_din_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic                  core_rst_no,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int          CW    = ADDR_WIDTH + 1;
    localparam int          TW    = $clog2(TIMEOUT + 1);
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_tcnt;
    logic [CW-1:0]         r_wcnt;
    logic [1:0]            r_idx;
    logic [7:0]            r_acc;
    logic [7:0]            r_cnt_lo;
    logic [15:0]           r_nwords;
    logic [23:0]           r_word;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_din;
    logic                  r_we;
    logic                  r_core_rst_n;

    logic                  w_ready;
    logic                  w_xfer;
    logic [15:0]           w_nwords;
    logic [CW-1:0]         w_wcnt_nxt;
    logic                  w_last_word;

    assign w_ready     = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_xfer      = byte_valid_i && w_ready;
    assign w_nwords    = {byte_i, r_cnt_lo};
    assign w_wcnt_nxt  = r_wcnt + 1'b1;
    assign w_last_word = (32'(w_wcnt_nxt) == 32'(r_nwords));

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= S_HDR0;
            r_tcnt       <= '0;
            r_wcnt       <= '0;
            r_idx        <= '0;
            r_acc        <= '0;
            r_cnt_lo     <= '0;
            r_nwords     <= '0;
            r_word       <= '0;
            r_addr       <= '0;
            r_din        <= '0;
            r_we         <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            // Core reset trails RUN by one cycle on entry and drops with the reload sample.
            r_core_rst_n <= (r_state == S_RUN) && !reload_i;
            case (r_state)
                S_HDR0: begin
                    if (w_xfer) begin
                        r_cnt_lo <= byte_i;
                        r_state  <= S_HDR1;
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_state <= S_RUN;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_HDR1: begin
                    if (w_xfer) begin
                        r_nwords <= w_nwords;
                        if (w_nwords == 16'd0)
                            r_state <= S_CSUM;
                        else if (32'(w_nwords) > DEPTH)
                            r_state <= S_ERROR;
                        else
                            r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_acc <= r_acc + byte_i;
                        if (r_idx == 2'd3) begin
                            r_we   <= 1'b1;
                            r_din  <= {byte_i, r_word};
                            r_addr <= r_wcnt[ADDR_WIDTH-1:0];
                            r_wcnt <= w_wcnt_nxt;
                            r_idx  <= 2'd0;
                            if (w_last_word)
                                r_state <= S_CSUM;
                        end else begin
                            r_word[8*r_idx +: 8] <= byte_i;
                            r_idx                <= r_idx + 2'd1;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer)
                        r_state <= (byte_i == r_acc) ? S_RUN : S_ERROR;
                end
                S_RUN, S_ERROR: begin
                    if (reload_i) begin
                        r_state <= S_HDR0;
                        r_tcnt  <= '0;
                        r_wcnt  <= '0;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                default: r_state <= S_ERROR;
            endcase
        end
    end

    assign byte_ready_o = w_ready;
    assign busy_o       = w_ready;
    assign err_o        = (r_state == S_ERROR);
    assign core_rst_no  = r_core_rst_n;
    assign mem_we_o     = r_we;
    assign mem_be_o     = {4{r_we}};
    assign mem_addr_o   = r_addr;
    assign mem_din_o    = r_din;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: image writes are queued as bytes are driven
// and matched against every memory write strobe observed.
module tb_boot_loader;

    localparam int AW = 10;
    localparam int TO = 1000;

    logic          clk_i;
    logic          rst_in;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          reload_i;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_din_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic          core_rst_no;
    logic          busy_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    logic [31:0]   img[$];
    logic [AW-1:0] mon_addr;
    logic [31:0]   mon_data;
    logic [AW-1:0] last_wr_addr;

    boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i        (clk_i),
        .rst_in       (rst_in),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .reload_i     (reload_i),
        .mem_addr_o   (mem_addr_o),
        .mem_din_o    (mem_din_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .core_rst_no  (core_rst_no),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (mem_we_o === 1'b1) begin
            checks++;
            last_wr_addr = mem_addr_o;
            if (exp_data_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%08h, no write expected", mem_addr_o, mem_din_o);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_data = exp_data_q.pop_front();
                if (mem_addr_o !== mon_addr || mem_din_o !== mon_data || mem_be_o !== 4'hF) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%0h data=%08h be=%h, expected addr=%0h data=%08h be=f",
                             mem_addr_o, mem_din_o, mem_be_o, mon_addr, mon_data);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            byte_valid_i = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_i);
        checks++;
        if (byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL byte_ready: got %b while sending %02h, expected 1", byte_ready_o, b);
        end
        byte_i       = b;
        byte_valid_i = 1'b1;
    endtask

    task automatic send_image(input int n, input logic [7:0] csum_delta, input int gap);
        logic [7:0]  sum;
        logic [31:0] w;
        sum = 8'h00;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8]);
                sum = sum + w[8*b +: 8];
                if (b == 3) begin
                    exp_addr_q.push_back(i[AW-1:0]);
                    exp_data_q.push_back(w);
                end
                if (gap > 0) idle(gap);
            end
        end
        send_byte(sum + csum_delta);
        idle(1);
    endtask

    task automatic wait_core_high(output int cyc);
        cyc = 0;
        while (core_rst_no !== 1'b1 && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_in       = 1'b0;
        byte_valid_i = 1'b0;
        reload_i     = 1'b0;
        byte_i       = 8'h00;
        #1;
        checks++;
        if ({mem_we_o, mem_be_o, core_rst_no, err_o, busy_o, byte_ready_o} !== 9'b0_0000_0_0_1_1 ||
            mem_addr_o !== '0 || mem_din_o !== '0) begin
            errors++;
            $display("FAIL reset_values: we=%b be=%h core=%b err=%b busy=%b ready=%b addr=%0h din=%08h, expected 0 0 0 0 1 1 0 0",
                     mem_we_o, mem_be_o, core_rst_no, err_o, busy_o, byte_ready_o, mem_addr_o, mem_din_o);
        end
        @(negedge clk_i);
        rst_in = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_i);
        rst_in       = 1'b0;
        byte_i       = 8'hA5;
        byte_valid_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({mem_we_o, core_rst_no, err_o, busy_o, byte_ready_o} !== 5'b0_0_0_1_1) begin
            errors++;
            $display("FAIL reset_hold: we=%b core=%b err=%b busy=%b ready=%b, expected 0 0 0 1 1",
                     mem_we_o, core_rst_no, err_o, busy_o, byte_ready_o);
        end
        byte_valid_i = 1'b0;
        rst_in       = 1'b1;
    endtask

    task automatic test_good_image();
        int cyc;
        do_reset();
        img.delete();
        img.push_back(32'h0000_0013);
        img.push_back(32'h0000_006F);
        send_image(2, 8'h00, 0);
        wait_core_high(cyc);
        checks++;
        if (core_rst_no !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL good_image_run: core=%b err=%b busy=%b ready=%b, expected 1 0 0 0",
                     core_rst_no, err_o, busy_o, byte_ready_o);
        end
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL good_image_writes: %0d writes missing, expected 0", exp_data_q.size());
        end
        @(negedge clk_i);
        byte_i       = 8'h55;
        byte_valid_i = 1'b1;
        idle(3);
        checks++;
        if (core_rst_no !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL run_drop_byte: core=%b busy=%b, expected 1 0", core_rst_no, busy_o);
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        img.delete();
        img.push_back(32'h0000_0013);
        img.push_back(32'h0000_006F);
        send_image(2, 8'h01, 0);
        idle(3);
        checks++;
        if (err_o !== 1'b1 || core_rst_no !== 1'b0 || busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bad_csum_error: err=%b core=%b busy=%b ready=%b, expected 1 0 0 0",
                     err_o, core_rst_no, busy_o, byte_ready_o);
        end
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL bad_csum_writes: %0d writes missing, expected 0", exp_data_q.size());
        end
        @(negedge clk_i);
        byte_i       = 8'h00;
        byte_valid_i = 1'b1;
        idle(2);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: err=%b after dropped bytes, expected 1", err_o);
        end
        @(negedge clk_i);
        reload_i = 1'b1;
        @(negedge clk_i);
        reload_i = 1'b0;
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL error_reload: err=%b busy=%b, expected 0 1", err_o, busy_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        n = 0;
        while (n < 1100) begin
            @(posedge clk_i);
            n++;
            #1;
            if (core_rst_no === 1'b1) break;
        end
        checks++;
        if (n < 1001 || n > 1002) begin
            errors++;
            $display("FAIL timeout_boot: core released after %0d cycles, expected 1001..1002", n);
        end
    endtask

    task automatic test_oversize();
        do_reset();
        send_byte(8'h01);
        send_byte(8'h04);
        idle(1);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || core_rst_no !== 1'b0) begin
            errors++;
            $display("FAIL oversize_error: err=%b busy=%b core=%b, expected 1 0 0", err_o, busy_o, core_rst_no);
        end
        idle(4);
    endtask

    task automatic test_full_depth();
        int cyc;
        do_reset();
        img.delete();
        for (int i = 0; i < 1024; i++) img.push_back($urandom);
        send_image(1024, 8'h00, 0);
        wait_core_high(cyc);
        checks++;
        if (core_rst_no !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL full_depth_run: core=%b err=%b, expected 1 0", core_rst_no, err_o);
        end
        checks++;
        if (exp_data_q.size() != 0 || last_wr_addr !== 10'h3FF) begin
            errors++;
            $display("FAIL full_depth_last: last addr=%0h missing=%0d, expected 3ff 0", last_wr_addr, exp_data_q.size());
        end
    endtask

    task automatic test_reload();
        int cyc;
        @(negedge clk_i);
        reload_i = 1'b1;
        @(negedge clk_i);
        reload_i = 1'b0;
        checks++;
        if (core_rst_no !== 1'b0 || busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reload_enter: core=%b busy=%b ready=%b, expected 0 1 1", core_rst_no, busy_o, byte_ready_o);
        end
        img.delete();
        send_image(0, 8'h00, 0);
        wait_core_high(cyc);
        checks++;
        if (core_rst_no !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reload_empty_run: core=%b err=%b, expected 1 0", core_rst_no, err_o);
        end
    endtask

    task automatic test_async_abort();
        int cyc;
        do_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        @(negedge clk_i);
        byte_i       = 8'h00;
        byte_valid_i = 1'b1;
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({mem_we_o, mem_be_o, core_rst_no, err_o, busy_o, byte_ready_o} !== 9'b0_0000_0_0_1_1 ||
            mem_addr_o !== '0 || mem_din_o !== '0) begin
            errors++;
            $display("FAIL abort_reset: we=%b be=%h core=%b err=%b busy=%b ready=%b addr=%0h, expected 0 0 0 0 1 1 0",
                     mem_we_o, mem_be_o, core_rst_no, err_o, busy_o, byte_ready_o, mem_addr_o);
        end
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        rst_in = 1'b1;
        img.delete();
        img.push_back(32'h0000_0013);
        img.push_back(32'h0000_006F);
        send_image(2, 8'h00, 0);
        wait_core_high(cyc);
        checks++;
        if (core_rst_no !== 1'b1 || exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL abort_reload: core=%b missing=%0d, expected 1 0", core_rst_no, exp_data_q.size());
        end
    endtask

    task automatic test_gapped();
        int cyc;
        do_reset();
        img.delete();
        img.push_back(32'hDEAD_BEEF);
        img.push_back(32'h0102_0304);
        img.push_back(32'hFFFF_FF80);
        send_image(3, 8'h00, 2);
        wait_core_high(cyc);
        checks++;
        if (core_rst_no !== 1'b1 || err_o !== 1'b0 || exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL gapped_image: core=%b err=%b missing=%0d, expected 1 0 0",
                     core_rst_no, err_o, exp_data_q.size());
        end
    endtask

    initial begin
        rst_in       = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        reload_i     = 1'b0;
        last_wr_addr = '0;
        test_reset();
        test_good_image();
        test_bad_csum();
        test_timeout();
        test_oversize();
        test_full_depth();
        test_reload();
        test_async_abort();
        test_gapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
